// File: rtl/la_scanreg_pkg.sv
// Shared constants and helpers for the la_scanreg scan-register bank.
package la_scanreg_pkg;

    // Stage and shadow flops reset to ones; replicate this bit to the bank width.
    localparam logic RST_BIT = 1'b1;

    function automatic int scnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/la_scanreg_cnt.sv
// Saturating shift-cycle counter: counts se=1 edges up to DW, clears on any se=0 edge.
import la_scanreg_pkg::*;

module la_scanreg_cnt #(
    parameter  int DW = 8,
    localparam int CW = scnt_width(DW)
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          se,
    output logic [CW-1:0] scnt,
    output logic          sdone
);

    logic [CW-1:0] scnt_q;
    logic [CW-1:0] scnt_d;

    always_comb begin
        scnt_d = '0;
        if (se) begin
            scnt_d = (scnt_q == CW'(DW)) ? scnt_q : scnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            scnt_q <= '0;
        end else begin
            scnt_q <= scnt_d;
        end
    end

    // Decoded from the registered count only, so sdone cannot glitch.
    assign scnt  = scnt_q;
    assign sdone = (scnt_q == CW'(DW));

endmodule

// File: rtl/la_scanreg_bank.sv
// Bank of inverting-output scan flops with shift counter.
// Define LA_SCANREG_SHADOW_EN to add a shadow/update stage that freezes qn while shifting.
import la_scanreg_pkg::*;

module la_scanreg_bank #(
    parameter int    DW   = 8,
    parameter string PROP = "DEFAULT",
    localparam int   CW   = scnt_width(DW)
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [DW-1:0] d,
    input  logic          en,
    input  logic          se,
    input  logic          si,
    input  logic          upd,
    output logic [DW-1:0] qn,
    output logic          so,
    output logic [CW-1:0] scnt,
    output logic          sdone
);

    logic [DW-1:0] stage_q;
    logic [DW-1:0] stage_d;

    // Scan enters at the top and exits at bit 0, so the first bit in lands on so after DW shifts.
    always_comb begin
        stage_d = stage_q;
        if (se) begin
            stage_d = {si, stage_q[DW-1:1]};
        end else if (en) begin
            stage_d = d;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            stage_q <= {DW{RST_BIT}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign so = stage_q[0];

`ifdef LA_SCANREG_SHADOW_EN
    logic [DW-1:0] shadow_q;
    logic [DW-1:0] shadow_d;

    // Shadow samples the pre-edge stage, so upd alongside en publishes the old value.
    always_comb begin
        shadow_d = shadow_q;
        if (upd && !se) begin
            shadow_d = stage_q;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            shadow_q <= {DW{RST_BIT}};
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign qn = ~shadow_q;
`else
    logic unused_upd;
    assign unused_upd = upd;
    assign qn = ~stage_q;
`endif

    la_scanreg_cnt #(
        .DW (DW)
    ) u_cnt (
        .clk    (clk),
        .nreset (nreset),
        .se     (se),
        .scnt   (scnt),
        .sdone  (sdone)
    );

endmodule

// File: tb/tb_la_scanreg_bank.sv
// Directed self-checking bench for la_scanreg_bank (DW=8); honours LA_SCANREG_SHADOW_EN.
module tb_la_scanreg_bank;

    localparam int DW = 8;
    localparam int CW = $clog2(DW + 1);

    logic          clk = 1'b0;
    logic          nreset;
    logic [DW-1:0] d;
    logic          en;
    logic          se;
    logic          si;
    logic          upd;
    logic [DW-1:0] qn;
    logic          so;
    logic [CW-1:0] scnt;
    logic          sdone;

    int n_cmp = 0;
    int n_mis = 0;

    la_scanreg_bank #(
        .DW   (DW),
        .PROP ("DEFAULT")
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .d      (d),
        .en     (en),
        .se     (se),
        .si     (si),
        .upd    (upd),
        .qn     (qn),
        .so     (so),
        .scnt   (scnt),
        .sdone  (sdone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sbits;
    logic [7:0] qn_frz;

    initial begin
        nreset = 1'b0; d = '0; en = 1'b0; se = 1'b0; si = 1'b0; upd = 1'b0;
        sbits = 8'b0100_1101;   // bit 0 is the first si bit shifted in
        #12;
        chk("rst_qn", qn, 8'h00);
        chk("rst_so", so, 1'b1);
        chk("rst_scnt", scnt, 0);
        chk("rst_sdone", sdone, 1'b0);
        nreset = 1'b1;
        tick();

        // Capture A5, then hold with en=0
        en = 1'b1; d = 8'hA5;
        tick();
`ifdef LA_SCANREG_SHADOW_EN
        chk("cap_pre_upd_qn", qn, 8'h00);
`else
        chk("cap_qn", qn, 8'h5A);
`endif
        en = 1'b0; upd = 1'b1;
        tick();
        upd = 1'b0;
        chk("cap_upd_qn", qn, 8'h5A);
        chk("cap_so", so, 1'b1);
        d = 8'hFF;
        tick();
        chk("hold_qn", qn, 8'h5A);

        // Asynchronous reset between edges
        #2 nreset = 1'b0;
        #1;
        chk("arst_qn", qn, 8'h00);
        chk("arst_so", so, 1'b1);
        nreset = 1'b1;
        tick();

        // Load zero, then shift 1,0,1,1,0,0,1,0
        en = 1'b1; d = 8'h00;
        tick();
        en = 1'b0;
        qn_frz = qn;
`ifndef LA_SCANREG_SHADOW_EN
        chk("load0_qn", qn, 8'hFF);
`endif
        se = 1'b1;
        for (int i = 0; i < 8; i++) begin
            si = sbits[i];
            tick();
            chk($sformatf("sh%0d_so", i + 1), so, (i == 7) ? 1'b1 : 1'b0);
            chk($sformatf("sh%0d_scnt", i + 1), scnt, i + 1);
            chk($sformatf("sh%0d_sdone", i + 1), sdone, (i == 7) ? 1'b1 : 1'b0);
`ifdef LA_SCANREG_SHADOW_EN
            chk($sformatf("sh%0d_qn_frozen", i + 1), qn, 8'h00);
`endif
        end
`ifndef LA_SCANREG_SHADOW_EN
        chk("sh_stage_qn", qn, 8'hB2);
`endif

        // Ninth shift saturates the counter; stage 4D -> 26
        si = 1'b0;
        tick();
        chk("sh9_scnt", scnt, 8);
        chk("sh9_sdone", sdone, 1'b1);
        chk("sh9_so", so, 1'b0);

        // se beats en: stage 26 -> 13, not 00
        en = 1'b1; d = 8'h00; si = 1'b0;
        tick();
        chk("prio_so", so, 1'b1);
        chk("prio_scnt", scnt, 8);
`ifndef LA_SCANREG_SHADOW_EN
        chk("prio_qn", qn, 8'hEC);
`else
        chk("prio_qn_frozen", qn, qn_frz);
`endif
        se = 1'b0; en = 1'b0;
        tick();
        chk("sedrop_scnt", scnt, 0);
        chk("sedrop_sdone", sdone, 1'b0);
        chk("sedrop_so", so, 1'b1);
`ifndef LA_SCANREG_SHADOW_EN
        chk("sedrop_qn", qn, 8'hEC);
`endif

`ifdef LA_SCANREG_SHADOW_EN
        // upd during shift is ignored; stage 13 -> 89
        se = 1'b1; upd = 1'b1; si = 1'b1;
        tick();
        chk("upd_se_qn", qn, 8'h00);
        se = 1'b0;
        tick();
        chk("upd_qn", qn, 8'h76);
        // upd with en publishes the pre-capture stage
        en = 1'b1; d = 8'h3C;
        tick();
        chk("upd_en_qn", qn, 8'h76);
        en = 1'b0;
        tick();
        chk("upd_after_qn", qn, 8'hC3);
        upd = 1'b0;
`endif

        // Reset in the middle of a shift burst
        se = 1'b1; si = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_scnt5", scnt, 5);
        #2 nreset = 1'b0;
        #1;
        chk("mid_rst_scnt", scnt, 0);
        chk("mid_rst_so", so, 1'b1);
        chk("mid_rst_qn", qn, 8'h00);
        nreset = 1'b1;
        tick();
        chk("mid_resume_scnt", scnt, 1);
        chk("mid_resume_so", so, 1'b1);
        se = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
